sha_1_pad: RTL and testbench
============================

Name: sha_1_pad

Overview:
- Message front end for the SHA-1 core: accepts a message as a stream of 32-bit big-endian words and emits padded 512-bit blocks ready for compression.
- Padding per FIPS 180-4: append 0x80, zero-fill, then the 64-bit big-endian message bit length; emits one or two final blocks as required.
- Output handshake plus first/last block markers tell the core when to reload initial H values and when the digest is final.

Parameters:
- LEN_W, 64, width of internal bit-length counter (fixed by SHA-1; wraps modulo 2^64)

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-low
- in_data  input  32  message word; byte 0 in [31:24]
- in_bytes  input  3  valid bytes in word (4 unless in_last; 0..4 allowed with in_last)
- in_last  input  1  final word of message
- in_valid  input  1  word valid
- in_ready  output  1  word accepted when in_valid & in_ready
- out_data  output  512  padded block; word 0 in [511:480]
- out_first  output  1  block is first of message
- out_last  output  1  block is final of message
- out_valid  output  1  block valid
- out_ready  input  1  block consumed when out_valid & out_ready

Behaviour:
- Reset (rst==0 at clk edge): state COLLECT, word_cnt=0, bitlen=0, first_flag=1, out_valid=0, out_first=0, out_last=0, out_data=0; in_ready=0 while rst==0.
- States: COLLECT, SEND, PAD2.
- COLLECT: in_ready=1. Accepted word is written to buffer slot word_cnt, with bytes beyond in_bytes masked to 0; bitlen += 8*in_bytes.
- Non-last word with word_cnt==15 -> SEND, with out_last=0.
- Last word at index w with k bytes gives byte position p=4w+k.
  - If p<64: byte p = 0x80.
  - All buffer bytes after the padding byte are zeroed.
  - p<=55: bytes 56..63 = bitlen including the final word; out_last=1; -> SEND.
  - p>55: out_last=0; -> SEND, then PAD2 pending.
- SEND: in_ready=0; out_valid=1 from the cycle after the accepting handshake (1-cycle latency).
  - out_data, out_first and out_last are held stable until out_ready.
  - On handshake: out_valid=0; first_flag cleared. If a PAD2 is pending -> PAD2; else word_cnt=0 -> COLLECT.
  - If the block was last: bitlen=0 and first_flag=1.
- PAD2: builds a block of all zeros, byte 0 = 0x80 if p==64, bytes 56..63 = bitlen.
  - out_first=0, out_last=1, out_valid asserted the following cycle; -> SEND, no further pending.
- out_first = first_flag at block build time.
- Empty message (in_bytes=0, in_last, w=0) produces a single block: 0x80000000, zeros, length 0.
- in_bytes==0 without in_last: word ignored for length and buffer, word_cnt not advanced.
- Reset mid-message or mid-SEND discards all partial state; out_valid drops on the reset edge.
- bitlen wraps modulo 2^64 with no error.

Optional Feature:
- Macro SHA_1_PAD_BSWAP_EN.
- Defined: in_data is byte-swapped on input (byte 0 in [7:0]). in_bytes still counts from byte 0, and masking/padding is applied after the swap.
- Undefined: in_data used as-is, big-endian.

Decomposition:
- sha_const package gets:
  - SHA1_BLOCK_BITS=512, SHA1_WORDS=16, SHA1_LEN_BYTE=56
  - padding byte constant 8'h80
  - typedef enum pad_state_t {COLLECT, SEND, PAD2}
- Natural sub-module sha_1_pad_word: combinational masking of a word to in_bytes with 0x80 insertion at position k; used for the final word and for slot w+1 when k==4.

Test Plan:
- "abc": in_data=0x61626300, in_bytes=3, in_last -> one block 0x61626380, 13 zero words, 0x00000000, 0x00000018; out_first=1, out_last=1.
- Empty message: in_bytes=0, in_last -> block 0x80000000, zeros, length 0; first=last=1.
- 56-byte message (14 full words, last on word 13) -> block 1: data, byte 56=0x80, rest 0, out_last=0; block 2: zeros, length 0x1C0, out_first=0, out_last=1.
- 64-byte message (16 full words, last on word 15) -> block 1 raw data, out_last=0; block 2 byte 0=0x80, length 0x200, out_last=1.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> out_data/out_first/out_last stable, in_ready=0; follow-on message after handshake -> out_first=1, length restarts from 0.
- Reset mid-message: rst=0 after 7 words, then "abc" -> output identical to the "abc" case.
- With SHA_1_PAD_BSWAP_EN defined: "abc" driven as 0x00636261 -> same block as the "abc" case.

Source files
------------

// File: rtl/sha_1_pad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sha_1_pad_pkg
// Brief    : Shared constants and state type for the SHA-1 message padder.
// Revision : 1.0
// ============================================================================
package sha_1_pad_pkg;

  localparam int SHA1_BLOCK_BITS = 512;
  localparam int SHA1_WORDS      = 16;
  localparam int SHA1_LEN_BYTE   = 56;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SEND    = 2'd1,
    PAD2    = 2'd2
  } pad_state_t;

endpackage
`default_nettype wire

// File: rtl/sha_1_pad_if.sv
`default_nettype none
// ============================================================================
// Module   : sha_1_pad_if
// Brief    : Word-in / padded-block-out handshake bundle for sha_1_pad.
// Revision : 1.0
// ============================================================================
interface sha_1_pad_if;
  import sha_1_pad_pkg::*;

  logic [31:0]                in_data;
  logic [2:0]                 in_bytes;
  logic                       in_last;
  logic                       in_valid;
  logic                       in_ready;
  logic [SHA1_BLOCK_BITS-1:0] out_data;
  logic                       out_first;
  logic                       out_last;
  logic                       out_valid;
  logic                       out_ready;

  modport master (
    output in_data, in_bytes, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_first, out_last, out_valid
  );

  modport slave (
    input  in_data, in_bytes, in_last, in_valid, out_ready,
    output in_ready, out_data, out_first, out_last, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/sha_1_pad_word.sv
`default_nettype none
// ============================================================================
// Module   : sha_1_pad_word
// Brief    : Keeps the first i_bytes bytes of a word, optionally places the
//            0x80 pad byte right after them, zeroes the rest.
// Revision : 1.0
// ============================================================================
module sha_1_pad_word
  import sha_1_pad_pkg::*;
(
  input  wire logic [31:0] i_data,
  input  wire logic [2:0]  i_bytes,
  input  wire logic        i_pad,
  output logic [31:0]      o_word
);

  generate
    for (genvar b = 0; b < 4; b++) begin : g_byte
      assign o_word[31-8*b -: 8] =
          (3'(b) < i_bytes)           ? i_data[31-8*b -: 8] :
          (i_pad && (3'(b) == i_bytes)) ? PAD_BYTE : 8'h00;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/sha_1_pad.sv
`default_nettype none
// ============================================================================
// Module   : sha_1_pad
// Brief    : SHA-1 front end: packs 32-bit words into padded 512-bit blocks.
//            Optional macro SHA_1_PAD_BSWAP_EN: input words are byte-swapped.
// Revision : 1.0
// ============================================================================
module sha_1_pad
  import sha_1_pad_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  wire logic   clk,
  input  wire logic   rst,
  sha_1_pad_if.slave  bus
);

  pad_state_t  r_state, w_state_nx;
  logic [31:0] r_words [SHA1_WORDS];
  logic [3:0]  r_cnt;
  logic [LEN_W-1:0] r_bitlen;
  logic [LEN_W-1:0] w_bitlen_nx;
  logic        r_first_flag, r_first, r_last, r_valid, r_pend, r_pad80;
  logic [31:0] w_din, w_word, w_next_word;
  logic        w_accept, w_take, w_short;
  logic [6:0]  w_p;
  logic [SHA1_BLOCK_BITS-1:0] w_block;

`ifdef SHA_1_PAD_BSWAP_EN
  assign w_din = {bus.in_data[7:0], bus.in_data[15:8],
                  bus.in_data[23:16], bus.in_data[31:24]};
`else
  assign w_din = bus.in_data;
`endif

  assign bus.in_ready = rst && (r_state == COLLECT);
  assign w_accept     = bus.in_valid && rst && (r_state == COLLECT);
  // A zero-byte word is only meaningful when it closes the message.
  assign w_take       = w_accept && ((bus.in_bytes != 3'd0) || bus.in_last);
  assign w_bitlen_nx  = r_bitlen + LEN_W'({bus.in_bytes, 3'b000});
  assign w_p          = {1'b0, r_cnt, 2'b00} + {4'b0000, bus.in_bytes};
  assign w_short      = (w_p <= 7'(SHA1_LEN_BYTE - 1));

  sha_1_pad_word u_word (
    .i_data  (w_din),
    .i_bytes (bus.in_bytes),
    .i_pad   (bus.in_last),
    .o_word  (w_word)
  );

  // Pad byte spilling into the slot after a full final word.
  sha_1_pad_word u_next (
    .i_data  (32'h0),
    .i_bytes (3'd0),
    .i_pad   (1'b1),
    .o_word  (w_next_word)
  );

  always_comb begin
    w_block = '0;
    for (int i = 0; i < SHA1_WORDS; i++)
      w_block[SHA1_BLOCK_BITS-1-32*i -: 32] = r_words[i];
  end

  assign bus.out_data  = w_block;
  assign bus.out_first = r_first;
  assign bus.out_last  = r_last;
  assign bus.out_valid = r_valid;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= COLLECT;
    else      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      COLLECT: if (w_take && (bus.in_last || (r_cnt == 4'd15))) w_state_nx = SEND;
      SEND:    if (r_valid && bus.out_ready) w_state_nx = r_pend ? PAD2 : COLLECT;
      PAD2:    w_state_nx = SEND;
      default: w_state_nx = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < SHA1_WORDS; i++) r_words[i] <= '0;
      r_cnt        <= '0;
      r_bitlen     <= '0;
      r_first_flag <= 1'b1;
      r_first      <= 1'b0;
      r_last       <= 1'b0;
      r_valid      <= 1'b0;
      r_pend       <= 1'b0;
      r_pad80      <= 1'b0;
    end else begin
      case (r_state)
        COLLECT: if (w_take) begin
          r_bitlen <= w_bitlen_nx;
          if (!bus.in_last) begin
            r_words[r_cnt] <= w_word;
            r_cnt          <= r_cnt + 4'd1;
            if (r_cnt == 4'd15) begin
              r_valid <= 1'b1;
              r_first <= r_first_flag;
              r_last  <= 1'b0;
              r_pend  <= 1'b0;
            end
          end else begin
            for (int i = 0; i < SHA1_WORDS; i++) begin
              if (i == int'(r_cnt))
                r_words[i] <= w_word;
              else if ((i == int'(r_cnt) + 1) && (bus.in_bytes == 3'd4))
                r_words[i] <= w_next_word;
              else if (i > int'(r_cnt))
                r_words[i] <= '0;
            end
            if (w_short) begin
              r_words[SHA1_WORDS-2] <= w_bitlen_nx[63:32];
              r_words[SHA1_WORDS-1] <= w_bitlen_nx[31:0];
            end
            r_valid <= 1'b1;
            r_first <= r_first_flag;
            r_last  <= w_short;
            r_pend  <= !w_short;
            r_pad80 <= (w_p == 7'd64);
          end
        end
        SEND: if (r_valid && bus.out_ready) begin
          r_valid      <= 1'b0;
          r_first_flag <= 1'b0;
          r_pend       <= 1'b0;
          if (!r_pend) r_cnt <= '0;
          if (r_last) begin
            r_bitlen     <= '0;
            r_first_flag <= 1'b1;
          end
        end
        PAD2: begin
          for (int i = 0; i < SHA1_WORDS; i++) r_words[i] <= '0;
          if (r_pad80) r_words[0] <= {PAD_BYTE, 24'h0};
          r_words[SHA1_WORDS-2] <= r_bitlen[63:32];
          r_words[SHA1_WORDS-1] <= r_bitlen[31:0];
          r_first <= 1'b0;
          r_last  <= 1'b1;
          r_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha_1_pad.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha_1_pad
// Brief    : Self-checking bench for sha_1_pad against a byte-level padding model.
// Revision : 1.0
// ============================================================================
module tb_sha_1_pad;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sha_1_pad_if bus ();

  sha_1_pad #(.LEN_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]   g_msg [$];
  logic [511:0] exp_q [$];
  logic [511:0] act_last_blk;
  logic         act_last_first;
  int           act_n;

  typedef struct {
    int          len;
    int          nblk;
    logic [31:0] fin_w0;
    logic [31:0] fin_w15;
  } vec_t;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: msg || 0x80 || zeros to 56 mod 64 || 64-bit bit length, cut into 64-byte blocks.
  function automatic void build_model();
    logic [7:0]   q [$];
    logic [63:0]  bl;
    logic [511:0] blk;
    q  = g_msg;
    bl = 64'(g_msg.size()) * 64'd8;
    q.push_back(8'h80);
    while ((q.size() % 64) != 56) q.push_back(8'h00);
    for (int j = 7; j >= 0; j--) q.push_back(bl[8*j +: 8]);
    exp_q.delete();
    for (int b = 0; b < q.size() / 64; b++) begin
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = q[64*b+j];
      exp_q.push_back(blk);
    end
  endfunction

  function automatic logic [31:0] to_bus(input logic [31:0] w);
`ifdef SHA_1_PAD_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic send_word(input logic [31:0] data, input logic [2:0] nb, input logic last);
    int t = 0;
    bus.in_data  = to_bus(data);
    bus.in_bytes = nb;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) begin
      checks++; errors++;
      $display("FAIL in_ready timeout: got 0 expected 1");
    end else begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drive_msg(input bit ign);
    int n  = g_msg.size();
    int nw = (n == 0) ? 1 : (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      int          k;
      logic [31:0] d;
      k = (n - 4*w >= 4) ? 4 : n - 4*w;
      d = $urandom;
      for (int j = 0; j < 4; j++) if (j < k) d[31-8*j -: 8] = g_msg[4*w+j];
      if (ign && $urandom_range(0, 3) == 0) send_word($urandom, 3'd0, 1'b0);
      send_word(d, 3'(k), (w == nw - 1));
    end
  endtask

  task automatic recv_block(input logic [511:0] exp, input logic ef, input logic el, input int hold);
    logic [511:0] d;
    logic f, l;
    int t = 0;
    @(negedge clk);
    while (!bus.out_valid && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) begin
      checks++; errors++;
      $display("FAIL out_valid timeout: got 0 expected 1");
      return;
    end
    d = bus.out_data; f = bus.out_first; l = bus.out_last;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checks++;
      if (bus.out_data !== d || bus.out_first !== f || bus.out_last !== l ||
          bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL hold stability: got valid=%b in_ready=%b first=%b last=%b expected 1 0 %b %b",
                 bus.out_valid, bus.in_ready, bus.out_first, bus.out_last, f, l);
      end
    end
    chk("block data", d, exp);
    chk("out_first", 512'(f), 512'(ef));
    chk("out_last", 512'(l), 512'(el));
    act_last_blk   = d;
    act_last_first = f;
    act_n++;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_msg(input int hold, input bit ign);
    build_model();
    act_n = 0;
    fork
      drive_msg(ign);
      begin
        for (int b = 0; b < exp_q.size(); b++)
          recv_block(exp_q[b], (b == 0), (b == exp_q.size() - 1),
                     (hold < 0) ? int'($urandom_range(0, 3)) : hold);
      end
    join
  endtask

  task automatic load_msg(input int len);
    g_msg.delete();
    for (int i = 0; i < len; i++) g_msg.push_back(8'(8'h61 + (i % 26)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vt [4];
    logic [511:0] abc;
    int           t;

    abc = '0;
    abc[511:480] = 32'h61626380;
    abc[31:0]    = 32'h00000018;

    vt[0] = '{3,  1, 32'h61626380, 32'h00000018};
    vt[1] = '{0,  1, 32'h80000000, 32'h00000000};
    vt[2] = '{56, 2, 32'h00000000, 32'h000001C0};
    vt[3] = '{64, 2, 32'h80000000, 32'h00000200};

    bus.in_data = '0; bus.in_bytes = '0; bus.in_last = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", 512'(bus.out_valid), 512'(0));
    chk("reset out_first", 512'(bus.out_first), 512'(0));
    chk("reset out_last",  512'(bus.out_last),  512'(0));
    chk("reset out_data",  bus.out_data, '0);
    chk("reset in_ready",  512'(bus.in_ready), 512'(0));
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      load_msg(vt[i].len);
      run_msg(0, 1'b0);
      chk("block count", 512'(act_n), 512'(vt[i].nblk));
      chk("final word0", 512'(act_last_blk[511:480]), 512'(vt[i].fin_w0));
      chk("final word15", 512'(act_last_blk[31:0]), 512'(vt[i].fin_w15));
      chk("final first", 512'(act_last_first), 512'(vt[i].nblk == 1));
    end
    load_msg(3);
    run_msg(0, 1'b0);
    chk("abc full block", act_last_blk, abc);

    // Backpressure on one message, then a follow-on message.
    load_msg(3);
    run_msg(5, 1'b0);
    load_msg(3);
    run_msg(0, 1'b0);
    chk("follow-on abc", act_last_blk, abc);
    chk("follow-on first", 512'(act_last_first), 512'(1));

    // Reset after 7 words of a message.
    for (int w = 0; w < 7; w++) send_word($urandom, 3'd4, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid-msg reset in_ready", 512'(bus.in_ready), 512'(0));
    chk("mid-msg reset out_valid", 512'(bus.out_valid), 512'(0));
    rst = 1'b1;
    @(posedge clk); #1;
    load_msg(3);
    run_msg(0, 1'b0);
    chk("abc after reset", act_last_blk, abc);

    // Reset while a block is being offered.
    load_msg(3);
    drive_msg(1'b0);
    t = 0;
    @(negedge clk);
    while (!bus.out_valid && t < 2000) begin @(negedge clk); t++; end
    chk("send valid before reset", 512'(bus.out_valid), 512'(1));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("send reset out_valid", 512'(bus.out_valid), 512'(0));
    chk("send reset out_data", bus.out_data, '0);
    rst = 1'b1;
    @(posedge clk); #1;
    load_msg(5);
    run_msg(0, 1'b0);

    for (int r = 0; r < 25; r++) begin
      int len;
      len = int'($urandom_range(0, 140));
      g_msg.delete();
      for (int i = 0; i < len; i++) g_msg.push_back(8'($urandom));
      run_msg(-1, 1'b1);
      chk("random block count", 512'(act_n), 512'(exp_q.size()));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
